// File: rtl/pipe_playback_ctrl.sv
// pipe_playback_ctrl: USB pipe datapath sequencer for sound playback (okClk domain).
//
// Pipe-in words (two 16-bit samples each, low half first) are buffered in an
// internal FIFO. When select=0, a play machine primes on PRIME_LEVEL words, then
// emits one sample every max(rate_div,1) cycles, and zero samples on underrun.
// When select=1, the FIFO is read back word by word through the pipe-out port.
//
// Ports:
//   okClk          sole clock
//   mst_reset_n    asynchronous active-low reset
//   pipe_in_write  pipe-in word strobe
//   pipe_in_data   pipe-in word, [15:0] first sample, [31:16] second sample
//   pipe_out_read  pipe-out read strobe
//   pipe_out_data  pipe-out word: FIFO readback (select=1) or status (select=0)
//   select         0 = play, 1 = readback
//   rate_div       okClk cycles per output sample
//   sample_out     current sample, two's complement
//   sample_valid   one-cycle pulse when sample_out updates
//   fifo_level     FIFO word count
//   overflow       sticky: write arrived while FIFO full
//   underrun       sticky: FIFO ran empty while playing
module pipe_playback_ctrl #(
  parameter int unsigned DEPTH_LOG2  = 9,
  parameter int unsigned PRIME_LEVEL = 64
) (
  input  logic                okClk,
  input  logic                mst_reset_n,
  input  logic                pipe_in_write,
  input  logic [31:0]         pipe_in_data,
  input  logic                pipe_out_read,
  output logic [31:0]         pipe_out_data,
  input  logic                select,
  input  logic [31:0]         rate_div,
  output logic [15:0]         sample_out,
  output logic                sample_valid,
  output logic [DEPTH_LOG2:0] fifo_level,
  output logic                overflow,
  output logic                underrun
);

  localparam int unsigned PW    = DEPTH_LOG2;
  localparam int unsigned LW    = DEPTH_LOG2 + 1;
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [31:0] EMPTY_READ_WORD = 32'hDEAD_0000;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PRIME    = 2'd1,
    ST_PLAY     = 2'd2,
    ST_UNDERRUN = 2'd3
  } state_e;

  // Registers
  logic [31:0]   mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  state_e        state_q, state_d;
  logic [31:0]   rate_cnt_q, rate_cnt_d;
  logic          half_q, half_d;
  logic [15:0]   sample_q, sample_d;
  logic          valid_q, valid_d;
  logic          overflow_q, overflow_d;
  logic          underrun_q, underrun_d;
  logic [15:0]   urun_cnt_q, urun_cnt_d;
  logic [31:0]   pipe_out_q, pipe_out_d;

  // Combinational helpers
  logic [31:0] head_c;
  logic        empty_c, full_c, primed_c;
  logic [31:0] div_max_c;
  logic        term_c;
  logic        play_pop_c, discard_pop_c, rb_read_c, rb_pop_c, pop_c, wr_en_c;
  logic [11:0] level12_c;

  assign head_c    = mem_q[rd_ptr_q];
  assign empty_c   = (level_q == LW'(0));
  assign full_c    = (level_q == LW'(DEPTH));
  assign primed_c  = (level_q >= LW'(PRIME_LEVEL));
  assign div_max_c = (rate_div == 32'd0) ? 32'd1 : rate_div;
  // >= rather than == so a shrinking rate_div wraps the counter immediately
  assign term_c    = (rate_cnt_q >= (div_max_c - 32'd1));
  assign level12_c = 12'(level_q);

  // Play machine, readback pops and status/readback output word
  always_comb begin
    state_d       = state_q;
    rate_cnt_d    = rate_cnt_q;
    half_d        = half_q;
    sample_d      = sample_q;
    valid_d       = 1'b0;
    underrun_d    = underrun_q;
    urun_cnt_d    = urun_cnt_q;
    play_pop_c    = 1'b0;
    discard_pop_c = 1'b0;
    pipe_out_d    = pipe_out_q;

    if (select) begin
      // Readback forces the play machine idle; a half-played head word is dropped
      state_d    = ST_IDLE;
      sample_d   = 16'd0;
      half_d     = 1'b0;
      rate_cnt_d = 32'd0;
      if ((state_q == ST_PLAY) && half_q && !empty_c) begin
        discard_pop_c = 1'b1;
      end
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (primed_c) state_d = ST_PRIME;
        end
        ST_PRIME: begin
          rate_cnt_d = 32'd0;
          half_d     = 1'b0;
          state_d    = ST_PLAY;
        end
        ST_PLAY: begin
          if (term_c) begin
            rate_cnt_d = 32'd0;
            valid_d    = 1'b1;
            if (!empty_c) begin
              sample_d   = half_q ? head_c[31:16] : head_c[15:0];
              half_d     = ~half_q;
              play_pop_c = half_q;
            end else begin
              sample_d   = 16'd0;
              half_d     = 1'b0;
              underrun_d = 1'b1;
              urun_cnt_d = (urun_cnt_q == 16'hFFFF) ? urun_cnt_q : urun_cnt_q + 16'd1;
              state_d    = ST_UNDERRUN;
            end
          end else begin
            rate_cnt_d = rate_cnt_q + 32'd1;
          end
        end
        ST_UNDERRUN: begin
          sample_d = 16'd0;
          if (primed_c) state_d = ST_PRIME;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if (!select) begin
      pipe_out_d = {urun_cnt_q, level12_c, overflow_q, underrun_q, state_q};
    end else if (rb_read_c) begin
      pipe_out_d = empty_c ? EMPTY_READ_WORD : head_c;
    end
  end

  // The discard pop owns the read port in its single cycle
  assign rb_read_c = select && pipe_out_read && !discard_pop_c;
  assign rb_pop_c  = rb_read_c && !empty_c;
  assign pop_c     = play_pop_c | discard_pop_c | rb_pop_c;

  // A pop frees a slot in the same cycle, so a write at full is still accepted
  assign wr_en_c   = pipe_in_write && (!full_c || pop_c);

  // FIFO pointer, level and overflow next-state
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    if (wr_en_c) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_c)   rd_ptr_d = rd_ptr_q + PW'(1);
    unique case ({wr_en_c, pop_c})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    if (pipe_in_write && !wr_en_c) overflow_d = 1'b1;
  end

  // FIFO storage, no reset needed
  always_ff @(posedge okClk) begin
    if (wr_en_c) mem_q[wr_ptr_q] <= pipe_in_data;
  end

  // State registers
  always_ff @(posedge okClk or negedge mst_reset_n) begin
    if (!mst_reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      state_q    <= ST_IDLE;
      rate_cnt_q <= 32'd0;
      half_q     <= 1'b0;
      sample_q   <= 16'd0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
      underrun_q <= 1'b0;
      urun_cnt_q <= 16'd0;
      pipe_out_q <= 32'd0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      state_q    <= state_d;
      rate_cnt_q <= rate_cnt_d;
      half_q     <= half_d;
      sample_q   <= sample_d;
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
      underrun_q <= underrun_d;
      urun_cnt_q <= urun_cnt_d;
      pipe_out_q <= pipe_out_d;
    end
  end

  assign pipe_out_data = pipe_out_q;
  assign sample_out    = sample_q;
  assign sample_valid  = valid_q;
  assign fifo_level    = level_q;
  assign overflow      = overflow_q;
  assign underrun      = underrun_q;

endmodule

// File: tb/tb_pipe_playback_ctrl.sv
// Scoreboard bench for pipe_playback_ctrl: stimulus pushes expected samples and
// readback words into queues; a negedge monitor pops and compares them.
module tb_pipe_playback_ctrl;

  localparam int unsigned DL = 7;
  localparam int unsigned PL = 64;
  localparam logic [31:0] DEAD = 32'hDEAD_0000;

  logic        okClk = 1'b0;
  logic        mst_reset_n;
  logic        pipe_in_write;
  logic [31:0] pipe_in_data;
  logic        pipe_out_read;
  logic [31:0] pipe_out_data;
  logic        select;
  logic [31:0] rate_div;
  logic [15:0] sample_out;
  logic        sample_valid;
  logic [DL:0] fifo_level;
  logic        overflow;
  logic        underrun;

  pipe_playback_ctrl #(.DEPTH_LOG2(DL), .PRIME_LEVEL(PL)) dut (
    .okClk         (okClk),
    .mst_reset_n   (mst_reset_n),
    .pipe_in_write (pipe_in_write),
    .pipe_in_data  (pipe_in_data),
    .pipe_out_read (pipe_out_read),
    .pipe_out_data (pipe_out_data),
    .select        (select),
    .rate_div      (rate_div),
    .sample_out    (sample_out),
    .sample_valid  (sample_valid),
    .fifo_level    (fifo_level),
    .overflow      (overflow),
    .underrun      (underrun)
  );

  always #5 okClk = ~okClk;

  typedef struct {
    logic [15:0] s;
    int          gap;   // required cycles since previous pulse, 0 = unchecked
  } samp_t;

  samp_t       exp_samp[$];
  logic [31:0] exp_rd[$];
  int          checks = 0;
  int          errors = 0;

  function automatic logic [31:0] mkw(input logic [15:0] base, input int i);
    return {base + 16'h0100 + 16'(i), base + 16'(i)};
  endfunction

  // Monitor: sample pulses and readback words one cycle after each strobe
  initial begin : monitor
    int    cyc = 0;
    int    last_cyc = -1000;
    logic  prev_rd = 1'b0;
    samp_t e;
    logic [31:0] w;
    forever begin
      @(negedge okClk);
      cyc++;
      if (!mst_reset_n) begin
        prev_rd = 1'b0;
      end else begin
        if (sample_valid) begin
          checks++;
          if (exp_samp.size() == 0) begin
            errors++;
            $display("FAIL sample_unexpected: got %h, no sample expected", sample_out);
          end else begin
            e = exp_samp.pop_front();
            if (sample_out !== e.s) begin
              errors++;
              $display("FAIL sample_value: got %h, expected %h", sample_out, e.s);
            end
            if (e.gap != 0) begin
              checks++;
              if (cyc - last_cyc != e.gap) begin
                errors++;
                $display("FAIL sample_gap: got %0d cycles, expected %0d", cyc - last_cyc, e.gap);
              end
            end
          end
          last_cyc = cyc;
        end
        if (prev_rd) begin
          checks++;
          if (exp_rd.size() == 0) begin
            errors++;
            $display("FAIL read_unexpected: got %h, no read expected", pipe_out_data);
          end else begin
            w = exp_rd.pop_front();
            if (pipe_out_data !== w) begin
              errors++;
              $display("FAIL read_word: got %h, expected %h", pipe_out_data, w);
            end
          end
        end
        prev_rd = select && pipe_out_read;
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge okClk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic op(input logic wr, input logic [31:0] d, input logic rd);
    pipe_in_write = wr;
    pipe_in_data  = d;
    pipe_out_read = rd;
    cycles(1);
    pipe_in_write = 1'b0;
    pipe_out_read = 1'b0;
  endtask

  task automatic do_reset();
    mst_reset_n = 1'b0;
    cycles(2);
    mst_reset_n = 1'b1;
    cycles(1);
  endtask

  task automatic push_samples(input logic [15:0] base, input int nwords, input int gap);
    logic [31:0] w;
    samp_t e;
    for (int i = 0; i < nwords; i++) begin
      w = mkw(base, i);
      e.s = w[15:0];  e.gap = (i == 0) ? 0 : gap; exp_samp.push_back(e);
      e.s = w[31:16]; e.gap = gap;                exp_samp.push_back(e);
    end
    e.s = 16'd0; e.gap = gap; exp_samp.push_back(e);
  endtask

  task automatic wait_samples(input string name, input int budget);
    int n = 0;
    while (exp_samp.size() != 0 && n < budget) begin
      cycles(1);
      n++;
    end
    checks++;
    if (exp_samp.size() != 0) begin
      errors++;
      $display("FAIL %s: timeout with %0d samples outstanding, expected 0", name, exp_samp.size());
    end
    cycles(2);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    mst_reset_n   = 1'b0;
    pipe_in_write = 1'b0;
    pipe_in_data  = 32'd0;
    pipe_out_read = 1'b0;
    select        = 1'b0;
    rate_div      = 32'd4;
    cycles(2);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_status", pipe_out_data, 32'd0);
    chk("rst_flags", {30'd0, overflow, underrun}, 32'd0);
    mst_reset_n = 1'b1;
    cycles(1);

    // Priming at rate_div=4
    for (int i = 0; i < PL - 1; i++) op(1'b1, mkw(16'h1000, i), 1'b0);
    cycles(3);
    chk("prime_63_level", 32'(fifo_level), 32'd63);
    chk("prime_63_state", 32'(pipe_out_data[1:0]), 32'd0);
    push_samples(16'h1000, PL, 4);
    op(1'b1, mkw(16'h1000, PL - 1), 1'b0);
    cycles(4);
    chk("prime_64_state", 32'(pipe_out_data[1:0]), 32'd2);
    wait_samples("prime_drain", 1500);
    chk("prime_underrun", 32'(underrun), 32'd1);

    // Underrun at rate_div=1
    do_reset();
    rate_div = 32'd1;
    push_samples(16'h2000, PL, 1);
    for (int i = 0; i < PL; i++) op(1'b1, mkw(16'h2000, i), 1'b0);
    wait_samples("urun_drain", 500);
    chk("urun_flag", 32'(underrun), 32'd1);
    chk("urun_sample", 32'(sample_out), 32'd0);
    chk("urun_status", pipe_out_data, 32'h0001_0007);
    op(1'b0, 32'd0, 1'b1);
    cycles(1);
    chk("status_read_nop", pipe_out_data, 32'h0001_0007);

    // Resume from UNDERRUN with rate_div=0
    rate_div = 32'd0;
    push_samples(16'h3000, PL, 1);
    for (int i = 0; i < PL; i++) op(1'b1, mkw(16'h3000, i), 1'b0);
    wait_samples("resume_drain", 500);
    chk("resume_status", pipe_out_data, 32'h0002_0007);

    // Reset mid-PLAY with level 100
    rate_div = 32'd1000;
    for (int i = 0; i < 100; i++) op(1'b1, mkw(16'h4000, i), 1'b0);
    cycles(3);
    chk("midplay_level", 32'(fifo_level), 32'd100);
    chk("midplay_state", 32'(pipe_out_data[3:0]), 32'h6);
    mst_reset_n = 1'b0;
    #1;
    chk("async_level", 32'(fifo_level), 32'd0);
    chk("async_sample", {15'd0, sample_valid, sample_out}, 32'd0);
    chk("async_flags", {30'd0, overflow, underrun}, 32'd0);
    chk("async_status", pipe_out_data, 32'd0);
    cycles(2);
    mst_reset_n = 1'b1;
    select = 1'b1;
    cycles(1);

    // Readback: fill, write+pop at full, overflow, drain, empty reads
    for (int i = 0; i < (1 << DL); i++) op(1'b1, mkw(16'h5000, i), 1'b0);
    cycles(1);
    chk("full_level", 32'(fifo_level), 32'd128);
    chk("full_overflow", 32'(overflow), 32'd0);
    exp_rd.push_back(mkw(16'h5000, 0));
    op(1'b1, 32'h1234_5678, 1'b1);
    cycles(1);
    chk("full_wrpop_level", 32'(fifo_level), 32'd128);
    chk("full_wrpop_ovf", 32'(overflow), 32'd0);
    op(1'b1, 32'hFFFF_0001, 1'b0);
    cycles(1);
    chk("ovf_level", 32'(fifo_level), 32'd128);
    chk("ovf_flag", 32'(overflow), 32'd1);
    for (int i = 1; i < (1 << DL); i++) exp_rd.push_back(mkw(16'h5000, i));
    exp_rd.push_back(32'h1234_5678);
    for (int i = 0; i < (1 << DL); i++) op(1'b0, 32'd0, 1'b1);
    exp_rd.push_back(DEAD);
    op(1'b0, 32'd0, 1'b1);
    cycles(1);
    chk("drained_level", 32'(fifo_level), 32'd0);
    exp_rd.push_back(DEAD);
    op(1'b1, 32'hCAFE_F00D, 1'b1);
    cycles(1);
    chk("empty_wrpop_level", 32'(fifo_level), 32'd1);
    exp_rd.push_back(32'hCAFE_F00D);
    op(1'b0, 32'd0, 1'b1);
    cycles(1);
    chk("final_level", 32'(fifo_level), 32'd0);
    chk("rb_sample_zero", 32'(sample_out), 32'd0);
    chk("rb_ovf_sticky", 32'(overflow), 32'd1);
    cycles(2);
    chk("rd_queue_empty", 32'(exp_rd.size()), 32'd0);
    chk("samp_queue_empty", 32'(exp_samp.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
